// File: rtl/sort_ctrl.sv
// sort_ctrl: packs a serial word stream into the parallel sort network input, waits out the
// sorter latency, then streams the sorted words back out. `define SORT_CTRL_FLUSH_EN adds a flush port.
module sort_ctrl #(
  parameter int NUM_VALS = 5,
  parameter int SIZE     = 16,
  parameter int SORT_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef SORT_CTRL_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     s_valid,
  input  logic [SIZE-1:0]          s_data,
  output logic                     s_ready,
  output logic [NUM_VALS*SIZE-1:0] sort_in,
  input  logic [NUM_VALS*SIZE-1:0] sort_out,
  output logic                     m_valid,
  output logic [SIZE-1:0]          m_data,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy
);

  localparam int IDX_W = (NUM_VALS > 2) ? $clog2(NUM_VALS) : 1;
  localparam int CNT_W = (SORT_LAT > 0) ? $clog2(SORT_LAT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALS - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SORT_LAT);

  typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, nextIdx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0]  fillWords_q [NUM_VALS];
  logic [SIZE-1:0]  fillWords_d [NUM_VALS];
  logic [SIZE-1:0]  outBuf_q [NUM_VALS];
  logic [SIZE-1:0]  outBuf_d [NUM_VALS];
  logic [SIZE-1:0]  sortedWords [NUM_VALS];
  logic             mValid_q, mValid_d;
  logic             mLast_q, mLast_d;
  logic             busy_q, busy_d;
  logic [SIZE-1:0]  mData_q, mData_d;

  // Word slot 0 (first received / smallest sorted) lives in the MSB position of the vectors.
  for (genvar g = 0; g < NUM_VALS; g++) begin : g_pack
    assign sort_in[(NUM_VALS-1-g)*SIZE +: SIZE] = fillWords_q[g];
    assign sortedWords[g] = sort_out[(NUM_VALS-1-g)*SIZE +: SIZE];
  end

  assign s_ready = (state_q == FILL) && !rst;
  assign m_valid = mValid_q;
  assign m_data  = mData_q;
  assign m_last  = mLast_q;
  assign busy    = busy_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    fillWords_d = fillWords_q;
    outBuf_d    = outBuf_q;
    mValid_d    = mValid_q;
    mData_d     = mData_q;
    mLast_d     = mLast_q;
    nextIdx     = idx_q + 1'b1;

    case (state_q)
      FILL: begin
        if (s_valid && s_ready) begin
          fillWords_d[idx_q] = s_data;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end else begin
            idx_d = nextIdx;
          end
        end
      end
      WAIT: begin
        // The sorter output is only trusted once the counter has run out.
        if (cnt_q == '0) begin
          outBuf_d = sortedWords;
          mData_d  = sortedWords[0];
          mLast_d  = (idx_q == LAST_IDX);
          mValid_d = 1'b1;
          state_d  = DRAIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRAIN: begin
        if (m_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d    = '0;
            mValid_d = 1'b0;
            mLast_d  = 1'b0;
            state_d  = FILL;
          end else begin
            idx_d   = nextIdx;
            mData_d = outBuf_q[nextIdx];
            mLast_d = (nextIdx == LAST_IDX);
          end
        end
      end
      default: state_d = FILL;
    endcase

`ifdef SORT_CTRL_FLUSH_EN
    // Flush wins over any handshake; stored vectors and m_data are left untouched.
    if (flush) begin
      state_d     = FILL;
      idx_d       = '0;
      cnt_d       = '0;
      mValid_d    = 1'b0;
      mLast_d     = 1'b0;
      mData_d     = mData_q;
      fillWords_d = fillWords_q;
      outBuf_d    = outBuf_q;
    end
`endif

    busy_d = (state_d != FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      idx_q    <= '0;
      cnt_q    <= '0;
      mValid_q <= 1'b0;
      mData_q  <= '0;
      mLast_q  <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < NUM_VALS; i++) begin
        fillWords_q[i] <= '0;
        outBuf_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      mValid_q    <= mValid_d;
      mData_q     <= mData_d;
      mLast_q     <= mLast_d;
      busy_q      <= busy_d;
      fillWords_q <= fillWords_d;
      outBuf_q    <= outBuf_d;
    end
  end

endmodule

// File: tb/tb_sort_ctrl.sv
// Directed bench for sort_ctrl: one DUT with a combinational sorter model and one with a
// 3-stage pipelined sorter model, selected by 'sel'. Flush scenarios need SORT_CTRL_FLUSH_EN.
module tb_sort_ctrl;
  localparam int NV = 5;
  localparam int SZ = 16;
  localparam int W  = NV * SZ;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          sel;
  logic          s_valid, m_ready, flush;
  logic [SZ-1:0] s_data;

  logic          sValid0, sValid3, mReady0, mReady3;
  logic          sReady0, sReady3, mValid0, mValid3, mLast0, mLast3, busy0, busy3;
  logic [SZ-1:0] mData0, mData3;
  logic [W-1:0]  sortIn0, sortIn3, sortOut0, sortOut3;
  logic [W-1:0]  pipe [3];

  logic          s_ready, m_valid, m_last, busy;
  logic [SZ-1:0] m_data;
  logic [W-1:0]  sort_in;

  int            checks = 0;
  int            errors = 0;
  logic [SZ-1:0] gotData [NV];
  logic          gotLast [NV];
  int            gotCount;
  int            gotWait;

  assign sValid0 = s_valid & ~sel;
  assign sValid3 = s_valid & sel;
  assign mReady0 = m_ready & ~sel;
  assign mReady3 = m_ready & sel;
  assign s_ready = sel ? sReady3 : sReady0;
  assign m_valid = sel ? mValid3 : mValid0;
  assign m_data  = sel ? mData3  : mData0;
  assign m_last  = sel ? mLast3  : mLast0;
  assign busy    = sel ? busy3   : busy0;
  assign sort_in = sel ? sortIn3 : sortIn0;

  // Ascending reference sorter: smallest word lands in the MSB slot (out1).
  function automatic logic [W-1:0] sortVec(input logic [W-1:0] v);
    logic [SZ-1:0] a [NV];
    logic [SZ-1:0] t;
    for (int i = 0; i < NV; i++) a[i] = v[(NV-1-i)*SZ +: SZ];
    for (int i = 0; i < NV - 1; i++)
      for (int j = 0; j < NV - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    sortVec = '0;
    for (int i = 0; i < NV; i++) sortVec[(NV-1-i)*SZ +: SZ] = a[i];
  endfunction

  assign sortOut0 = sortVec(sortIn0);
  always_ff @(posedge clk) begin
    pipe[0] <= sortVec(sortIn3);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign sortOut3 = pipe[2];

  sort_ctrl #(.NUM_VALS(NV), .SIZE(SZ), .SORT_LAT(0)) dut0 (
    .clk(clk), .rst(rst),
`ifdef SORT_CTRL_FLUSH_EN
    .flush(flush),
`endif
    .s_valid(sValid0), .s_data(s_data), .s_ready(sReady0),
    .sort_in(sortIn0), .sort_out(sortOut0),
    .m_valid(mValid0), .m_data(mData0), .m_ready(mReady0), .m_last(mLast0), .busy(busy0)
  );

  sort_ctrl #(.NUM_VALS(NV), .SIZE(SZ), .SORT_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
`ifdef SORT_CTRL_FLUSH_EN
    .flush(flush),
`endif
    .s_valid(sValid3), .s_data(s_data), .s_ready(sReady3),
    .sort_in(sortIn3), .sort_out(sortOut3),
    .m_valid(mValid3), .m_data(mData3), .m_ready(mReady3), .m_last(mLast3), .busy(busy3)
  );

  // Drives one batch (word 0 taken from the MSB slot of v); optional idle cycle between words.
  task automatic feedBatch(input logic [W-1:0] v, input bit gaps);
    int guard;
    for (int i = 0; i < NV; i++) begin
      guard   = 0;
      s_valid = 1'b1;
      s_data  = v[(NV-1-i)*SZ +: SZ];
      while (!s_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!s_ready) begin
        checks++; errors++;
        $display("[TB] FAIL feed_timeout: s_ready=%0b required 1", s_ready);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      if (gaps && i < NV - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Waits (bounded) for m_valid, then records words with m_ready held high.
  task automatic collectBatch(input int budget);
    gotCount = 0;
    gotWait  = 0;
    m_ready  = 1'b1;
    while (!m_valid && gotWait < budget) begin
      @(posedge clk); #1;
      gotWait++;
    end
    while (m_valid && gotCount < NV) begin
      gotData[gotCount] = m_data;
      gotLast[gotCount] = m_last;
      gotCount++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; flush = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("[TB] FAIL reset_outputs sel=%0d: m_valid=%0b m_data=%0d m_last=%0b busy=%0b required 0", s, m_valid, m_data, m_last, busy); end
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready sel=%0d: got %0b required 0", s, s_ready); end
      checks++;
      if (sort_in !== '0) begin errors++; $display("[TB] FAIL reset_sort_in sel=%0d: got %h required 0", s, sort_in); end
    end
    sel = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sReady0 !== 1'b1 || sReady3 !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_s_ready: got %0b/%0b required 1/1", sReady0, sReady3); end
  endtask

  task automatic test_basic();
    logic [SZ-1:0] expd [NV] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
    sel = 1'b0; m_ready = 1'b1;
    feedBatch({16'd30, 16'd10, 16'd50, 16'd20, 16'd40}, 1'b0);
    checks++;
    if (sort_in !== {16'd30, 16'd10, 16'd50, 16'd20, 16'd40}) begin errors++; $display("[TB] FAIL basic_sort_in: got %h required 001e000a003200140028", sort_in); end
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0)
      begin errors++; $display("[TB] FAIL basic_wait: busy=%0b s_ready=%0b m_valid=%0b required 1/0/0", busy, s_ready, m_valid); end
    collectBatch(20);
    checks++;
    if (gotWait != 1) begin errors++; $display("[TB] FAIL basic_latency: got %0d edges required 1", gotWait); end
    checks++;
    if (gotCount != NV) begin errors++; $display("[TB] FAIL basic_count: got %0d words required %0d", gotCount, NV); end
    for (int k = 0; k < NV; k++) begin
      checks++;
      if (gotData[k] !== expd[k] || gotLast[k] !== (k == NV - 1))
        begin errors++; $display("[TB] FAIL basic_word%0d: got %0d last=%0b required %0d last=%0b", k, gotData[k], gotLast[k], expd[k], (k == NV - 1)); end
    end
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("[TB] FAIL basic_done: m_valid=%0b s_ready=%0b busy=%0b required 0/1/0", m_valid, s_ready, busy); end
  endtask

  task automatic test_pipelined();
    logic [SZ-1:0] expd [NV] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
    sel = 1'b1; m_ready = 1'b1;
    feedBatch({16'd30, 16'd10, 16'd50, 16'd20, 16'd40}, 1'b0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (busy !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0)
        begin errors++; $display("[TB] FAIL pipe_wait%0d: busy=%0b s_ready=%0b m_valid=%0b required 1/0/0", c, busy, s_ready, m_valid); end
      @(posedge clk); #1;
    end
    for (int k = 0; k < NV; k++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== expd[k] || m_last !== (k == NV - 1) || s_ready !== 1'b0 || busy !== 1'b1)
        begin errors++; $display("[TB] FAIL pipe_word%0d: valid=%0b data=%0d last=%0b s_ready=%0b busy=%0b required 1/%0d/%0b/0/1", k, m_valid, m_data, m_last, s_ready, busy, expd[k], (k == NV - 1)); end
      @(posedge clk); #1;
    end
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL pipe_done: m_valid=%0b busy=%0b s_ready=%0b required 0/0/1", m_valid, busy, s_ready); end
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [SZ-1:0] expd [NV] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
    int k;
    int cyc;
    sel = 1'b0; m_ready = 1'b0;
    feedBatch({16'd30, 16'd10, 16'd50, 16'd20, 16'd40}, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_start: m_valid=%0b required 1", m_valid); end
    k = 0; cyc = 0;
    while (m_valid && k < NV && cyc < 45) begin
      m_ready = (cyc % 3 == 2);
      checks++;
      if (m_data !== expd[k] || m_last !== (k == NV - 1))
        begin errors++; $display("[TB] FAIL bp_cycle%0d: data=%0d last=%0b required %0d/%0b", cyc, m_data, m_last, expd[k], (k == NV - 1)); end
      @(posedge clk); #1;
      if (m_ready) k++;
      cyc++;
    end
    m_ready = 1'b1;
    checks++;
    if (cyc != 15 || k != NV || m_valid !== 1'b0)
      begin errors++; $display("[TB] FAIL bp_length: cycles=%0d words=%0d m_valid=%0b required 15/5/0", cyc, k, m_valid); end
  endtask

  task automatic test_back_to_back();
    logic [SZ-1:0] expA [NV] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    logic [SZ-1:0] expB [NV] = '{16'd0, 16'd1, 16'd7, 16'd7, 16'd65535};
    sel = 1'b0; m_ready = 1'b1;
    feedBatch({16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
    checks++;
    if (sort_in !== {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}) begin errors++; $display("[TB] FAIL b2b_sort_in_a: got %h required 00050004000300020001", sort_in); end
    collectBatch(20);
    checks++;
    if (gotCount != NV) begin errors++; $display("[TB] FAIL b2b_count_a: got %0d required %0d", gotCount, NV); end
    for (int k = 0; k < NV; k++) begin
      checks++;
      if (gotData[k] !== expA[k] || gotLast[k] !== (k == NV - 1))
        begin errors++; $display("[TB] FAIL b2b_a_word%0d: got %0d last=%0b required %0d", k, gotData[k], gotLast[k], expA[k]); end
    end
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready: s_ready=%0b busy=%0b required 1/0", s_ready, busy); end
    feedBatch({16'd65535, 16'd0, 16'd7, 16'd7, 16'd1}, 1'b1);
    checks++;
    if (sort_in !== {16'd65535, 16'd0, 16'd7, 16'd7, 16'd1}) begin errors++; $display("[TB] FAIL b2b_sort_in_b: got %h required ffff0000000700070001", sort_in); end
    collectBatch(20);
    checks++;
    if (gotCount != NV) begin errors++; $display("[TB] FAIL b2b_count_b: got %0d required %0d", gotCount, NV); end
    for (int k = 0; k < NV; k++) begin
      checks++;
      if (gotData[k] !== expB[k] || gotLast[k] !== (k == NV - 1))
        begin errors++; $display("[TB] FAIL b2b_b_word%0d: got %0d last=%0b required %0d", k, gotData[k], gotLast[k], expB[k]); end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [SZ-1:0] expd [NV] = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    sel = 1'b0; m_ready = 1'b1;
    feedBatch({16'd30, 16'd10, 16'd50, 16'd20, 16'd40}, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'd30) begin errors++; $display("[TB] FAIL mid_drain_pre: valid=%0b data=%0d required 1/30", m_valid, m_data); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || m_last !== 1'b0 || m_data !== '0)
      begin errors++; $display("[TB] FAIL mid_drain_reset: valid=%0b busy=%0b s_ready=%0b last=%0b data=%0d required all 0", m_valid, busy, s_ready, m_last, m_data); end
    checks++;
    if (sort_in !== '0) begin errors++; $display("[TB] FAIL mid_drain_sort_in: got %h required 0", sort_in); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_drain_after: valid=%0b s_ready=%0b required 0/1", m_valid, s_ready); end
    feedBatch({16'd9, 16'd8, 16'd7, 16'd6, 16'd5}, 1'b0);
    collectBatch(20);
    checks++;
    if (gotCount != NV || gotWait != 1) begin errors++; $display("[TB] FAIL mid_drain_next: count=%0d wait=%0d required 5/1", gotCount, gotWait); end
    for (int k = 0; k < NV; k++) begin
      checks++;
      if (gotData[k] !== expd[k] || gotLast[k] !== (k == NV - 1))
        begin errors++; $display("[TB] FAIL mid_drain_word%0d: got %0d last=%0b required %0d", k, gotData[k], gotLast[k], expd[k]); end
    end
  endtask

`ifdef SORT_CTRL_FLUSH_EN
  task automatic test_flush();
    logic [SZ-1:0] expA [NV] = '{16'd11, 16'd22, 16'd33, 16'd44, 16'd55};
    logic [SZ-1:0] expB [NV] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    sel = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 16'(100 * (i + 1));
      @(posedge clk); #1;
    end
    flush = 1'b1; s_valid = 1'b1; s_data = 16'hDEAD;
    @(posedge clk); #1;
    flush = 1'b0; s_valid = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_fill: s_ready=%0b busy=%0b m_valid=%0b required 1/0/0", s_ready, busy, m_valid); end
    checks++;
    if (sort_in !== {16'd100, 16'd200, 16'd300, 16'd6, 16'd5}) begin errors++; $display("[TB] FAIL flush_hold_sort_in: got %h required 006400c8012c00060005", sort_in); end
    feedBatch({16'd44, 16'd11, 16'd33, 16'd55, 16'd22}, 1'b0);
    checks++;
    if (sort_in !== {16'd44, 16'd11, 16'd33, 16'd55, 16'd22}) begin errors++; $display("[TB] FAIL flush_clean_sort_in: got %h required 002c000b00210037 0016", sort_in); end
    collectBatch(20);
    for (int k = 0; k < NV; k++) begin
      checks++;
      if (k >= gotCount || gotData[k] !== expA[k]) begin errors++; $display("[TB] FAIL flush_clean_word%0d: got %0d required %0d", k, gotData[k], expA[k]); end
    end
    feedBatch({16'd44, 16'd11, 16'd33, 16'd55, 16'd22}, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'd22) begin errors++; $display("[TB] FAIL flush_drain_pre: valid=%0b data=%0d required 1/22", m_valid, m_data); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL flush_drain: valid=%0b last=%0b busy=%0b s_ready=%0b required 0/0/0/1", m_valid, m_last, busy, s_ready); end
    feedBatch({16'd3, 16'd1, 16'd2, 16'd5, 16'd4}, 1'b0);
    collectBatch(20);
    checks++;
    if (gotCount != NV || gotWait != 1) begin errors++; $display("[TB] FAIL flush_resume: count=%0d wait=%0d required 5/1", gotCount, gotWait); end
    for (int k = 0; k < NV; k++) begin
      checks++;
      if (gotData[k] !== expB[k] || gotLast[k] !== (k == NV - 1)) begin errors++; $display("[TB] FAIL flush_resume_word%0d: got %0d required %0d", k, gotData[k], expB[k]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_pipelined();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
`ifdef SORT_CTRL_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
